// File: rtl/pf_ram_banked.sv
// Banked playfield RAM: CPU byte-lane port, full-width video read port and a
// self-running clear engine that fills every word after reset or on request.
module pf_ram_banked #(
  parameter int unsigned        ADDR_W    = 8,
  parameter int unsigned        LANE_W    = 8,
  parameter int unsigned        LANES     = 4,
  parameter logic [LANE_W-1:0]  CLEAR_VAL = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_W-1:0]       cpu_addr,
  input  logic [LANE_W-1:0]       cpu_din,
  input  logic [LANES-1:0]        cpu_sel,
  input  logic                    cpu_we,
  output logic [LANE_W-1:0]       cpu_dout,
  input  logic [ADDR_W-1:0]       vid_addr,
  input  logic                    vid_rd,
  output logic [LANES*LANE_W-1:0] vid_dout,
  output logic                    vid_valid,
  input  logic                    clear_req,
  output logic                    busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    ST_CLEAR,
    ST_IDLE
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_W-1:0]       ptr_q, ptr_d;
  logic                    busy_q, busy_d;
  logic [LANE_W-1:0]       cpu_dout_q, cpu_dout_d;
  logic [LANES*LANE_W-1:0] vid_dout_q, vid_dout_d;
  logic                    vid_valid_q, vid_valid_d;

  logic [LANE_W-1:0]       mem [LANES][DEPTH];

  logic [LANES-1:0]        lane_we;
  logic [ADDR_W-1:0]       wr_addr;
  logic [LANE_W-1:0]       wr_data;
  logic                    access_ok;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cpu_dout_d  = cpu_dout_q;
    vid_dout_d  = vid_dout_q;
    vid_valid_d = 1'b0;
    lane_we     = '0;
    wr_addr     = cpu_addr;
    wr_data     = cpu_din;
    access_ok   = 1'b0;

    if (state_q == ST_CLEAR) begin
      lane_we    = '1;
      wr_addr    = ptr_q;
      wr_data    = CLEAR_VAL;
      ptr_d      = ptr_q + ADDR_W'(1);
      cpu_dout_d = '0;
      if (ptr_q == '1) begin
        state_d = ST_IDLE;
      end
    end else if (clear_req) begin
      // Accepting a clear drops whatever access is presented this cycle.
      state_d    = ST_CLEAR;
      cpu_dout_d = '0;
    end else begin
      access_ok = 1'b1;
    end

    if (access_ok) begin
      if (cpu_we) begin
        lane_we = cpu_sel;
      end else begin
        // Later lanes overwrite earlier ones: highest selected lane wins.
        cpu_dout_d = '0;
        for (int unsigned n = 0; n < LANES; n++) begin
          if (cpu_sel[n]) begin
            cpu_dout_d = mem[n][cpu_addr];
          end
        end
      end

      if (vid_rd) begin
        vid_valid_d = 1'b1;
        for (int unsigned n = 0; n < LANES; n++) begin
          if (cpu_we && cpu_sel[n] && (cpu_addr == vid_addr)) begin
            vid_dout_d[n*LANE_W +: LANE_W] = cpu_din;
          end else begin
            vid_dout_d[n*LANE_W +: LANE_W] = mem[n][vid_addr];
          end
        end
      end
    end

    busy_d = (state_d == ST_CLEAR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_CLEAR;
      ptr_q       <= '0;
      busy_q      <= 1'b1;
      cpu_dout_q  <= '0;
      vid_dout_q  <= '0;
      vid_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      busy_q      <= busy_d;
      cpu_dout_q  <= cpu_dout_d;
      vid_dout_q  <= vid_dout_d;
      vid_valid_q <= vid_valid_d;
    end
  end

  // Storage has no reset; the clear engine is the only initialiser.
  always_ff @(posedge clk) begin
    for (int unsigned n = 0; n < LANES; n++) begin
      if (lane_we[n]) begin
        mem[n][wr_addr] <= wr_data;
      end
    end
  end

  assign cpu_dout  = cpu_dout_q;
  assign vid_dout  = vid_dout_q;
  assign vid_valid = vid_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_pf_ram_banked.sv
// Scoreboard bench for pf_ram_banked: default instance plus a small
// 2-lane / 4-bit / 16-word instance with a non-zero clear value.
module tb_pf_ram_banked;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;

  logic [7:0]  cpu_addr, cpu_din, cpu_dout;
  logic [3:0]  cpu_sel;
  logic        cpu_we;
  logic [7:0]  vid_addr;
  logic        vid_rd, vid_valid;
  logic [31:0] vid_dout;
  logic        clear_req, busy;

  logic [3:0]  cpu_addr2, cpu_din2, cpu_dout2;
  logic [1:0]  cpu_sel2;
  logic        cpu_we2;
  logic [3:0]  vid_addr2;
  logic        vid_rd2, vid_valid2;
  logic [7:0]  vid_dout2;
  logic        clear_req2, busy2;

  pf_ram_banked dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_addr  (cpu_addr),
    .cpu_din   (cpu_din),
    .cpu_sel   (cpu_sel),
    .cpu_we    (cpu_we),
    .cpu_dout  (cpu_dout),
    .vid_addr  (vid_addr),
    .vid_rd    (vid_rd),
    .vid_dout  (vid_dout),
    .vid_valid (vid_valid),
    .clear_req (clear_req),
    .busy      (busy)
  );

  pf_ram_banked #(
    .ADDR_W    (4),
    .LANE_W    (4),
    .LANES     (2),
    .CLEAR_VAL (4'hA)
  ) dut2 (
    .clk       (clk),
    .reset     (reset),
    .cpu_addr  (cpu_addr2),
    .cpu_din   (cpu_din2),
    .cpu_sel   (cpu_sel2),
    .cpu_we    (cpu_we2),
    .cpu_dout  (cpu_dout2),
    .vid_addr  (vid_addr2),
    .vid_rd    (vid_rd2),
    .vid_dout  (vid_dout2),
    .vid_valid (vid_valid2),
    .clear_req (clear_req2),
    .busy      (busy2)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  string       cq_tag[$], vq_tag[$], v2q_tag[$];
  logic [31:0] cq[$], vq[$], v2q[$];

  logic  cpu_chk, vid_exp, vid_exp2;
  logic  s_cpu, s_vid_rd, s_vid_exp, s_vid_rd2, s_vid_exp2;
  string m_tag;
  logic [31:0] m_exp;

  always @(posedge clk) begin
    s_cpu      = cpu_chk;
    s_vid_rd   = vid_rd;
    s_vid_exp  = vid_exp;
    s_vid_rd2  = vid_rd2;
    s_vid_exp2 = vid_exp2;
    #1;
    if (s_cpu) begin
      if (cq.size() == 0) check("cpu_sb_empty", 32'd0, 32'd1);
      else begin
        m_tag = cq_tag.pop_front(); m_exp = cq.pop_front();
        check(m_tag, 32'(cpu_dout), m_exp);
      end
    end
    if (s_vid_rd || vid_valid) check("vid_valid", 32'(vid_valid), 32'(s_vid_exp));
    if (s_vid_exp) begin
      if (vq.size() == 0) check("vid_sb_empty", 32'd0, 32'd1);
      else begin
        m_tag = vq_tag.pop_front(); m_exp = vq.pop_front();
        check(m_tag, vid_dout, m_exp);
      end
    end
    if (s_vid_rd2 || vid_valid2) check("vid2_valid", 32'(vid_valid2), 32'(s_vid_exp2));
    if (s_vid_exp2) begin
      if (v2q.size() == 0) check("vid2_sb_empty", 32'd0, 32'd1);
      else begin
        m_tag = v2q_tag.pop_front(); m_exp = v2q.pop_front();
        check(m_tag, 32'(vid_dout2), m_exp);
      end
    end
  end

  task automatic idle();
    cpu_addr = '0; cpu_din = '0; cpu_sel = '0; cpu_we = 1'b0;
    vid_addr = '0; vid_rd = 1'b0; clear_req = 1'b0;
    cpu_addr2 = '0; cpu_din2 = '0; cpu_sel2 = '0; cpu_we2 = 1'b0;
    vid_addr2 = '0; vid_rd2 = 1'b0; clear_req2 = 1'b0;
    cpu_chk = 1'b0; vid_exp = 1'b0; vid_exp2 = 1'b0;
  endtask

  task automatic cpu_wr(input logic [7:0] a, input logic [3:0] s, input logic [7:0] d);
    cpu_addr = a; cpu_sel = s; cpu_din = d; cpu_we = 1'b1;
    @(negedge clk);
    idle();
  endtask

  task automatic cpu_rd(input string tag, input logic [7:0] a, input logic [3:0] s,
                        input logic [7:0] exp);
    cpu_addr = a; cpu_sel = s; cpu_we = 1'b0; cpu_chk = 1'b1;
    cq_tag.push_back(tag); cq.push_back(32'(exp));
    @(negedge clk);
    idle();
  endtask

  task automatic vid_read(input string tag, input logic [7:0] a, input logic [31:0] exp);
    vid_addr = a; vid_rd = 1'b1; vid_exp = 1'b1;
    vq_tag.push_back(tag); vq.push_back(exp);
    @(negedge clk);
    idle();
  endtask

  task automatic vid2_read(input string tag, input logic [3:0] a, input logic [7:0] exp);
    vid_addr2 = a; vid_rd2 = 1'b1; vid_exp2 = 1'b1;
    v2q_tag.push_back(tag); v2q.push_back(32'(exp));
    @(negedge clk);
    idle();
  endtask

  task automatic wait_busy(input string tag, input int exp_len, input bit second);
    int cnt;
    cnt = 0;
    while ((second ? busy2 : busy) && cnt < 1000) begin
      @(negedge clk);
      cnt++;
    end
    check(tag, 32'(cnt), 32'(exp_len));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    idle();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy",      32'(busy),      32'd1);
    check("rst_vid_valid", 32'(vid_valid), 32'd0);
    check("rst_cpu_dout",  32'(cpu_dout),  32'd0);
    check("rst_vid_dout",  vid_dout,       32'd0);
    reset = 1'b0;
    wait_busy("init_clear_len", 256, 1'b0);

    vid_read("init_00", 8'h00, 32'h0);
    vid_read("init_7f", 8'h7F, 32'h0);
    vid_read("init_ff", 8'hFF, 32'h0);

    cpu_wr(8'h40, 4'b0001, 8'h11);
    cpu_wr(8'h40, 4'b0100, 8'h22);
    vid_read("lanes_40", 8'h40, 32'h0022_0011);
    cpu_rd("rd_sel0101", 8'h40, 4'b0101, 8'h22);
    cpu_rd("rd_sel0000", 8'h40, 4'b0000, 8'h00);
    cpu_rd("rd_sel0001", 8'h40, 4'b0001, 8'h11);
    cpu_rd("rd_sel0111", 8'h40, 4'b0111, 8'h22);
    // Write cycle carrying a check: cpu_dout must hold the prior read.
    cpu_addr = 8'h41; cpu_sel = 4'b0001; cpu_din = 8'h99; cpu_we = 1'b1; cpu_chk = 1'b1;
    cq_tag.push_back("hold_on_write"); cq.push_back(32'h22);
    @(negedge clk);
    idle();

    cpu_wr(8'h10, 4'b0010, 8'hAA);
    vid_read("pre_collide", 8'h10, 32'h0000_AA00);
    cpu_addr = 8'h10; cpu_sel = 4'b0010; cpu_din = 8'h55; cpu_we = 1'b1;
    vid_addr = 8'h10; vid_rd = 1'b1; vid_exp = 1'b1;
    vq_tag.push_back("collide"); vq.push_back(32'h0000_5500);
    @(negedge clk);
    idle();
    cpu_addr = 8'h11; cpu_sel = 4'b0001; cpu_din = 8'hEE; cpu_we = 1'b1;
    vid_addr = 8'h10; vid_rd = 1'b1; vid_exp = 1'b1;
    vq_tag.push_back("no_collide"); vq.push_back(32'h0000_5500);
    @(negedge clk);
    idle();
    vid_read("post_collide", 8'h10, 32'h0000_5500);

    for (int a = 8'h80; a <= 8'h83; a++) cpu_wr(8'(a), 4'hF, 8'hFF);
    vid_read("fill_82", 8'h82, 32'hFFFF_FFFF);
    clear_req = 1'b1; vid_addr = 8'h80; vid_rd = 1'b1;
    @(negedge clk);
    idle();
    cnt = 0;
    while (busy && cnt < 1000) begin
      cpu_we = (cnt == 200); cpu_sel = 4'hF; cpu_addr = 8'h10; cpu_din = 8'h77;
      vid_addr = 8'h81; vid_rd = 1'b1;
      @(negedge clk);
      cnt++;
    end
    idle();
    check("req_clear_len", 32'(cnt), 32'd256);
    for (int a = 8'h80; a <= 8'h83; a++) vid_read("cleared_8x", 8'(a), 32'h0);
    vid_read("busy_write_dropped", 8'h10, 32'h0);
    cpu_rd("cleared_cpu_83", 8'h83, 4'b1000, 8'h00);

    cpu_wr(8'hFF, 4'hF, 8'h5A);
    vid_read("pre_ff", 8'hFF, 32'h5A5A_5A5A);
    clear_req = 1'b1;
    @(negedge clk);
    idle();
    repeat (99) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wait_busy("mid_reset_len", 256, 1'b0);
    vid_read("mid_reset_ff", 8'hFF, 32'h0);
    cpu_rd("mid_reset_cpu_ff", 8'hFF, 4'b1000, 8'h00);

    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wait_busy("p2_clear_len", 16, 1'b1);
    vid2_read("p2_init_3", 4'h3, 8'hAA);
    vid2_read("p2_init_f", 4'hF, 8'hAA);
    cpu_addr2 = 4'h3; cpu_sel2 = 2'b10; cpu_din2 = 4'h3; cpu_we2 = 1'b1;
    @(negedge clk);
    idle();
    vid2_read("p2_lane1_wr", 4'h3, 8'h3A);

    @(negedge clk);
    check("sb_drain", 32'(cq.size() + vq.size() + v2q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
